// File: rtl/mod_bit_feeder.sv
// Byte-to-symbol serialiser feeding the modulator: buffers bytes and emits MSB-first bursts of
// 1/2/4/6 bits on a fixed SYM_PERIOD-cycle slot grid.
module mod_bit_feeder #(
   parameter int unsigned SYM_PERIOD = 8
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_en,
   input  logic [1:0] i_mod,
   input  logic [7:0] i_byte,
   input  logic       i_byte_vld,
   output logic       o_byte_rdy,
   output logic       o_data_vld,
   output logic       o_data,
   output logic       o_underrun,
   output logic       o_busy
);

   localparam int unsigned CntW = (SYM_PERIOD > 1) ? $clog2(SYM_PERIOD) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(SYM_PERIOD - 1);

   typedef enum logic [1:0] {
      StIdle,
      StBurst,
      StGap
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bps_q, bps_d;
   logic [15:0]     buf_q, buf_d;
   logic [4:0]      fill_q, fill_d;
   logic            data_vld_q, data_vld_d;
   logic            data_q, data_d;
   logic            underrun_q, underrun_d;

   logic            load;
   logic            shift;
   logic            start_eval;
   logic            slot_end;
   logic            burst_more;
   logic [2:0]      bps_req;
   logic [15:0]     shifted;
   logic [4:0]      fill_base;

   function automatic logic [2:0] bps_of(input logic [1:0] m);
      logic [2:0] r;
      unique case (m)
         2'b00:   r = 3'd1;
         2'b01:   r = 3'd2;
         2'b10:   r = 3'd4;
         default: r = 3'd6;
      endcase
      return r;
   endfunction

   // At most 8 bits held means a whole byte always fits behind them.
   assign o_byte_rdy = ~i_rst & (fill_q <= 5'd8);
   assign load       = i_byte_vld & o_byte_rdy;
   assign bps_req    = bps_of(i_mod);
   assign slot_end   = (cnt_q == CntLast);
   assign burst_more = (32'(cnt_q) + 32'd1) < 32'(bps_q);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bps_d      = bps_q;
      shift      = 1'b0;
      data_vld_d = 1'b0;
      data_d     = data_q;
      underrun_d = 1'b0;
      start_eval = 1'b0;

      unique case (state_q)
         StIdle: start_eval = 1'b1;
         StBurst: begin
            cnt_d = cnt_q + CntW'(1);
            if (burst_more) begin
               shift      = 1'b1;
               data_vld_d = 1'b1;
               data_d     = buf_q[15];
            end else if (slot_end) begin
               start_eval = 1'b1;
            end else begin
               state_d = StGap;
            end
         end
         StGap: begin
            if (slot_end) begin
               start_eval = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase

      // Slot boundary: the first bit leaves on the same edge the slot starts.
      if (start_eval) begin
         cnt_d = '0;
         if (!i_en) begin
            state_d = StIdle;
         end else if (fill_q >= {2'b00, bps_req}) begin
            state_d    = StBurst;
            bps_d      = bps_req;
            shift      = 1'b1;
            data_vld_d = 1'b1;
            data_d     = buf_q[15];
         end else begin
            state_d    = StGap;
            underrun_d = 1'b1;
         end
      end
   end

   // Buffer is MSB-aligned; a new byte lands right behind the bits left after this edge's shift.
   always_comb begin
      shifted   = shift ? {buf_q[14:0], 1'b0} : buf_q;
      fill_base = fill_q - {4'b0000, shift};
      buf_d     = shifted;
      fill_d    = fill_base;
      if (load) begin
         buf_d  = shifted | ({i_byte, 8'h00} >> fill_base);
         fill_d = fill_base + 5'd8;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         bps_q      <= 3'd1;
         buf_q      <= '0;
         fill_q     <= '0;
         data_vld_q <= 1'b0;
         data_q     <= 1'b0;
         underrun_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bps_q      <= bps_d;
         buf_q      <= buf_d;
         fill_q     <= fill_d;
         data_vld_q <= data_vld_d;
         data_q     <= data_d;
         underrun_q <= underrun_d;
      end
   end

   assign o_data_vld = data_vld_q;
   assign o_data     = data_q;
   assign o_underrun = underrun_q;
   assign o_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_mod_bit_feeder.sv
// Bench for mod_bit_feeder: directed scenarios plus random runs checked against a bit-pool slot
// model (each slot takes BPS bits from the pool if it holds enough, otherwise it underruns).
module tb_mod_bit_feeder;

   logic       clk;
   logic       rst;
   logic       en;
   logic [1:0] mod;
   logic [7:0] byte_in;
   logic       byte_vld;
   logic       byte_rdy;
   logic       data_vld;
   logic       data;
   logic       underrun;
   logic       busy;

   mod_bit_feeder #(.SYM_PERIOD(8)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_en       (en),
      .i_mod      (mod),
      .i_byte     (byte_in),
      .i_byte_vld (byte_vld),
      .o_byte_rdy (byte_rdy),
      .o_data_vld (data_vld),
      .o_data     (data),
      .o_underrun (underrun),
      .o_busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int bps_tab [4] = '{1, 2, 4, 6};

   logic [7:0] feed [$];
   bit         pool [$];
   bit         obs_bits [$];
   int         burst_start [$];
   int         burst_len [$];
   int         urun_cyc [$];
   int         fill_log [$];
   bit         prev_vld = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      obs_bits.delete();
      burst_start.delete();
      burst_len.delete();
      urun_cyc.delete();
      fill_log.delete();
   endtask

   task automatic add_byte(input logic [7:0] b);
      feed.push_back(b);
      for (int i = 7; i >= 0; i--) pool.push_back(b[i]);
   endtask

   // One clock: present the feed head, advance, then log what the DUT shows after the edge.
   task automatic step();
      bit acc;
      int last;
      @(negedge clk);
      byte_vld = (feed.size() > 0);
      byte_in  = (feed.size() > 0) ? feed[0] : 8'h00;
      #1 acc = byte_vld && byte_rdy;
      @(posedge clk);
      cyc++;
      if (acc) void'(feed.pop_front());
      #1;
      fill_log.push_back(int'(dut.fill_q));
      if (data_vld) begin
         obs_bits.push_back(data);
         if (!prev_vld) begin
            burst_start.push_back(cyc);
            burst_len.push_back(1);
         end else begin
            last = burst_len.size() - 1;
            burst_len[last] = burst_len[last] + 1;
         end
      end
      prev_vld = data_vld;
      if (underrun) urun_cyc.push_back(cyc);
   endtask

   task automatic preload();
      en = 1'b0;
      repeat (3) step();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      en  = 1'b0;
      repeat (2) step();
      rst = 1'b0;
      pool.delete();
   endtask

   // Hold i_en for nslots slots in mode m and compare against the pool model.
   task automatic run_slots(input logic [1:0] m, input int nslots);
      int bps;
      int cyc0;
      bit exp_bits [$];
      int exp_bst [$];
      int exp_urn [$];
      int n;
      bps  = bps_tab[m];
      clear_logs();
      cyc0 = cyc;
      for (int s = 0; s < nslots; s++) begin
         if (pool.size() >= bps) begin
            exp_bst.push_back(cyc0 + 1 + 8 * s);
            for (int b = 0; b < bps; b++) exp_bits.push_back(pool.pop_front());
         end else begin
            exp_urn.push_back(cyc0 + 1 + 8 * s);
         end
      end
      mod = m;
      en  = 1'b1;
      repeat (8 * nslots) step();
      en = 1'b0;
      repeat (12) step();

      check("burst_count", burst_start.size(), exp_bst.size());
      n = (burst_start.size() < exp_bst.size()) ? burst_start.size() : exp_bst.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("burst_at[%0d]", i), burst_start[i], exp_bst[i]);
         check($sformatf("burst_len[%0d]", i), burst_len[i], bps);
      end
      check("bit_count", obs_bits.size(), exp_bits.size());
      n = (obs_bits.size() < exp_bits.size()) ? obs_bits.size() : exp_bits.size();
      for (int i = 0; i < n; i++) check($sformatf("bit[%0d]", i), obs_bits[i], exp_bits[i]);
      check("urun_count", urun_cyc.size(), exp_urn.size());
      n = (urun_cyc.size() < exp_urn.size()) ? urun_cyc.size() : exp_urn.size();
      for (int i = 0; i < n; i++) check($sformatf("urun_at[%0d]", i), urun_cyc[i], exp_urn[i]);
      check("busy_after", busy, 1'b0);
   endtask

   initial begin
      int cyc0;
      logic [1:0] m;
      int nb;

      rst      = 1'b1;
      en       = 1'b0;
      mod      = 2'b00;
      byte_in  = 8'h00;
      byte_vld = 1'b0;

      // Reset state
      repeat (3) step();
      check("rdy_in_reset", byte_rdy, 1'b0);
      check("vld_reset", data_vld, 1'b0);
      check("busy_reset", busy, 1'b0);
      check("urun_reset", underrun, 1'b0);
      check("data_reset", data, 1'b0);
      rst = 1'b0;
      #1 check("rdy_after_reset", byte_rdy, 1'b1);

      // Mode 00: 0xA5 over 8 slots
      add_byte(8'hA5);
      preload();
      run_slots(2'b00, 8);

      // Mode 11 with backpressure
      add_byte(8'hFF);
      add_byte(8'h00);
      add_byte(8'hF0);
      preload();
      check("bp_rdy_low", byte_rdy, 1'b0);
      check("bp_pending", feed.size(), 1);
      run_slots(2'b11, 4);
      check("bp_rdy_end", byte_rdy, 1'b1);

      // Underrun: 8 bits, mode 10, 4 slots
      add_byte(8'h3C);
      preload();
      run_slots(2'b10, 4);

      // Mid-slot mode/enable change
      add_byte(8'h96);
      add_byte(8'h3C);
      preload();
      clear_logs();
      cyc0 = cyc;
      mod  = 2'b10;
      en   = 1'b1;
      repeat (2) step();
      mod = 2'b01;
      en  = 1'b0;
      repeat (6) step();
      check("mid_busy_slot_end", busy, 1'b1);
      step();
      check("mid_busy_idle", busy, 1'b0);
      repeat (16) step();
      check("mid_burst_count", burst_start.size(), 1);
      check("mid_urun_count", urun_cyc.size(), 0);
      if (burst_start.size() > 0) begin
         check("mid_burst_at", burst_start[0], cyc0 + 1);
         check("mid_burst_len", burst_len[0], 4);
      end
      check("mid_bit_count", obs_bits.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < obs_bits.size()) check($sformatf("mid_bit[%0d]", i), obs_bits[i], pool[0]);
         void'(pool.pop_front());
      end
      run_slots(2'b01, 3);

      // Reset on the third bit of a mode-11 burst
      add_byte(8'hE7);
      preload();
      clear_logs();
      mod = 2'b11;
      en  = 1'b1;
      repeat (3) step();
      rst = 1'b1;
      en  = 1'b0;
      step();
      check("rst_vld", data_vld, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_rdy", byte_rdy, 1'b0);
      check("rst_partial_bits", obs_bits.size(), 3);
      for (int i = 0; i < 3; i++)
         if (i < obs_bits.size()) check($sformatf("rst_bit[%0d]", i), obs_bits[i], pool[i]);
      rst = 1'b0;
      #1 check("rst_rdy_release", byte_rdy, 1'b1);
      pool.delete();
      add_byte(8'h80);
      preload();
      run_slots(2'b00, 1);

      // Simultaneous load and shift at a mode-01 burst start with fill=8
      do_reset();
      add_byte(8'hB4);
      preload();
      add_byte(8'h6D);
      run_slots(2'b01, 8);
      check("ls_fill0", fill_log[0], 15);
      check("ls_fill1", fill_log[1], 14);

      // Random runs, each ending in underrun slots
      for (int r = 0; r < 6; r++) begin
         m  = 2'($urandom_range(0, 3));
         nb = $urandom_range(3, 10);
         for (int i = 0; i < nb; i++) add_byte(8'($urandom_range(0, 255)));
         preload();
         run_slots(m, pool.size() / bps_tab[m] + 2);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
